line_burst_ctrl: RTL

Cache-line burst sequencer. It sits directly upstream of the sram-like-to-AXI bridge and converts one cache-line refill or one dirty-line writeback into the bridge's handshake sequence. For a refill it drives one read-address phase and collects LINE_WORDS beats. For a writeback it drives one write-address phase, then LINE_WORDS write beats with the last one flagged, then waits for the write response.

---
 rtl/line_burst_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/line_burst_ctrl.sv
// rtl/line_burst_ctrl.sv - cache-line refill/writeback burst sequencer for the sram-to-AXI bridge
module line_burst_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int IDXW       = $clog2(LINE_WORDS)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            rd_req,
    input  logic [31:0]     rd_addr,
    output logic [31:0]     rd_word,
    output logic            rd_word_valid,
    output logic [IDXW-1:0] rd_word_idx,
    output logic            rd_done,
    input  logic            wr_req,
    input  logic [31:0]     wr_addr,
    output logic [IDXW-1:0] wr_data_idx,
    input  logic [31:0]     wr_data,
    output logic            wr_done,
    output logic            busy,
    output logic [3:0]      reqType,
    output logic            req,
    output logic            wr,
    output logic [1:0]      size,
    output logic [31:0]     addr,
    output logic [31:0]     sram_wdata,
    input  logic [31:0]     sram_rdata,
    input  logic            addr_ok,
    input  logic            data_ok,
    input  logic            wb_ok,
    output logic [7:0]      burst_len,
    output logic [2:0]      burst_size,
    output logic [1:0]      burst_type,
    output logic            burst_wlast,
    output logic            addr_awvalid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(LINE_WORDS - 1);
    localparam logic [31:0]     LINE_MASK = ~32'(LINE_WORDS * 4 - 1);

    state_t          state_q;
    state_t          state_d;
    logic [IDXW-1:0] cnt_q;
    logic [31:0]     addr_q;
    logic            last;

    assign last = (cnt_q == LAST_IDX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                // Writeback wins so the victim leaves before the refill overwrites its slot
                if (wr_req) begin
                    addr_q <= wr_addr & LINE_MASK;
                    cnt_q  <= '0;
                end else if (rd_req) begin
                    addr_q <= rd_addr & LINE_MASK;
                    cnt_q  <= '0;
                end
            end else if ((state_q == RD_DATA || state_q == WR_DATA) && data_ok) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_req)      state_d = WR_ADDR;
                else if (rd_req) state_d = RD_ADDR;
            end
            RD_ADDR: if (addr_ok)         state_d = RD_DATA;
            RD_DATA: if (data_ok && last) state_d = IDLE;
            WR_ADDR: if (addr_ok)         state_d = WR_DATA;
            WR_DATA: if (data_ok && last) state_d = WR_RESP;
            WR_RESP: if (wb_ok)           state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        req           = 1'b0;
        wr            = 1'b0;
        addr_awvalid  = 1'b0;
        burst_wlast   = 1'b0;
        rd_word_valid = 1'b0;
        rd_done       = 1'b0;
        wr_done       = 1'b0;
        case (state_q)
            RD_ADDR: req = 1'b1;
            RD_DATA: begin
                rd_word_valid = data_ok;
                rd_done       = data_ok && last;
            end
            WR_ADDR: begin
                addr_awvalid = 1'b1;
                wr           = 1'b1;
            end
            WR_DATA: begin
                req         = 1'b1;
                wr          = 1'b1;
                burst_wlast = last;
            end
            // wr stays high here: the bridge only honours wb_ok while wr is set
            WR_RESP: begin
                wr      = 1'b1;
                wr_done = wb_ok;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign addr        = addr_q;
    assign rd_word     = sram_rdata;
    assign rd_word_idx = cnt_q;
    assign wr_data_idx = cnt_q;
    assign sram_wdata  = wr_data;
    assign reqType     = 4'b0000;
    assign size        = 2'b10;
    assign burst_len   = 8'(LINE_WORDS - 1);
    assign burst_size  = 3'b010;
    assign burst_type  = 2'b01;

endmodule
